// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock FIFO with 2^N_log entries, DW-bit words, selectable
//   registered-read or first-word-fall-through output, almost-full /
//   almost-empty thresholds, an occupancy counter and sticky
//   overflow/underflow flags.
//
// Parameters
//   DW      data width in bits
//   N_log   log2 of depth
//   FWFT    0 = o_rd_data updates one cycle after an accepted read,
//           1 = o_rd_data shows the head word whenever o_empty = 0
//   AF_LVL  o_almost_full asserts when occupancy >= AF_LVL
//   AE_LVL  o_almost_empty asserts when occupancy <= AE_LVL
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   i_flush         synchronous discard of all contents
//   i_wr_data       write word
//   i_wr_en         write request
//   o_full          no free slot
//   o_almost_full   occupancy >= AF_LVL
//   i_rd_en         read / pop request
//   o_rd_data       read word
//   o_empty         no readable word
//   o_almost_empty  occupancy <= AE_LVL
//   o_words         occupancy, 0..2^N_log
//   o_overflow      sticky: write attempted while full
//   o_underflow     sticky: read attempted while empty
//
// Handshake: a write is accepted on an edge iff i_wr_en & ~o_full & ~i_flush;
// a read is accepted on an edge iff i_rd_en & ~o_empty & ~i_flush. o_full and
// o_empty are the registered pre-edge values, so there is no same-cycle
// bypass (write-while-full and read-while-empty are always rejected).
module fifo_sync_param #(
    parameter int DW     = 64,
    parameter int N_log  = 9,
    parameter int FWFT   = 0,
    parameter int AF_LVL = (2 ** N_log) - 4,
    parameter int AE_LVL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_wr_en,
    output logic             o_full,
    output logic             o_almost_full,
    input  logic             i_rd_en,
    output logic [DW-1:0]    o_rd_data,
    output logic             o_empty,
    output logic             o_almost_empty,
    output logic [N_log:0]   o_words,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int             DEPTH   = 2 ** N_log;
    localparam logic [N_log:0] DEPTH_W = (N_log + 1)'(DEPTH);
    localparam logic [N_log:0] AF_W    = (N_log + 1)'(AF_LVL);
    localparam logic [N_log:0] AE_W    = (N_log + 1)'(AE_LVL);

    logic [DW-1:0]    mem [DEPTH];
    logic [N_log-1:0] wr_ptr;
    logic [N_log-1:0] rd_ptr;

    logic             wr_acc;
    logic             rd_acc;
    logic [N_log:0]   words_nxt;
    logic [N_log-1:0] rd_ptr_nxt;
    logic [DW-1:0]    head_nxt;

    assign wr_acc = i_wr_en & ~o_full  & ~i_flush;
    assign rd_acc = i_rd_en & ~o_empty & ~i_flush;

    always_comb begin
        words_nxt = o_words;
        case ({wr_acc, rd_acc})
            2'b10:   words_nxt = o_words + 1'b1;
            2'b01:   words_nxt = o_words - 1'b1;
            default: words_nxt = o_words;
        endcase
    end

    // Head word as it will be after this edge. When the head slot is the
    // one being written right now (FIFO empty or draining to the write
    // slot), the incoming word has to be forwarded since memory does not
    // hold it yet.
    always_comb begin
        rd_ptr_nxt = rd_acc ? rd_ptr + 1'b1 : rd_ptr;
        head_nxt   = mem[rd_ptr_nxt];
        if (wr_acc && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = i_wr_data;
        end
    end

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and all status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_words        <= '0;
            o_full         <= 1'b0;
            o_almost_full  <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_words        <= '0;
            o_full         <= 1'b0;
            o_almost_full  <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr         <= rd_ptr_nxt;
            o_words        <= words_nxt;
            o_full         <= (words_nxt == DEPTH_W);
            o_empty        <= (words_nxt == '0);
            o_almost_full  <= (words_nxt >= AF_W);
            o_almost_empty <= (words_nxt <= AE_W);
            o_overflow     <= o_overflow  | (i_wr_en & o_full);
            o_underflow    <= o_underflow | (i_rd_en & o_empty);
        end
    end

    // Output word. Registered mode loads only on an accepted read and
    // holds otherwise; FWFT mode tracks the post-edge head every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data <= '0;
        end else if (FWFT != 0) begin
            if (!i_flush) begin
                o_rd_data <= head_nxt;
            end
        end else if (rd_acc) begin
            o_rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data width in bits (1..512).
REQ-002 SHALL have parameter N_log, default 9, meaning log2 of depth (depth = 2^N_log, 2..12).
REQ-003 SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LVL, default 2^N_log-4, meaning the word count at or above which o_almost_full asserts.
REQ-005 SHALL have parameter AE_LVL, default 4, meaning the word count at or below which o_almost_empty asserts.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-008 SHALL have port i_flush, input, 1, meaning synchronous discard of all contents.
REQ-009 SHALL have port i_wr_data, input, DW, meaning the write word.
REQ-010 SHALL have port i_wr_en, input, 1, meaning the write request.
REQ-011 SHALL have port o_full, output, 1, meaning no free slot.
REQ-012 SHALL have port o_almost_full, output, 1, meaning words >= AF_LVL.
REQ-013 SHALL have port i_rd_en, input, 1, meaning the read/pop request.
REQ-014 SHALL have port o_rd_data, output, DW, meaning the read word.
REQ-015 SHALL have port o_empty, output, 1, meaning no readable word.
REQ-016 SHALL have port o_almost_empty, output, 1, meaning words <= AE_LVL.
REQ-017 SHALL have port o_words, output, N_log+1, meaning the current occupancy, 0..2^N_log.
REQ-018 SHALL have port o_overflow, output, 1, meaning sticky: a write was attempted while full.
REQ-019 SHALL have port o_underflow, output, 1, meaning sticky: a read was attempted while empty.

Function
REQ-020 SHALL accept a write iff i_wr_en & ~o_full & ~i_flush, storing i_wr_data at wr_ptr and incrementing wr_ptr modulo 2^N_log.
REQ-021 SHALL accept a read iff i_rd_en & ~o_empty & ~i_flush, incrementing rd_ptr modulo 2^N_log.
REQ-022 SHALL evaluate o_full and o_empty on pre-edge state only, with no same-cycle bypass: a write while full is rejected even with a concurrent read, and a read while empty is rejected even with a concurrent write.
REQ-023 SHALL update o_words on the edge as +1 (write only), -1 (read only), or unchanged (both or neither); o_full = (o_words == 2^N_log), o_empty = (o_words == 0); all status outputs registered.
REQ-024 SHALL, with FWFT=0, present the word at the accepted read address on o_rd_data exactly one cycle after the accepting edge, and hold it until the next accepted read.
REQ-025 SHALL, with FWFT=1, present the head word on o_rd_data whenever o_empty=0, starting the cycle after the write edge that filled an empty FIFO; an accepted read shows the next word (or sets o_empty) after that edge.
REQ-026 SHALL treat o_rd_data as don't-care when o_empty=1 in FWFT mode.
REQ-027 SHALL handle pointer wrap from 2^N_log-1 to 0 transparently, with no data loss or reordering.
REQ-028 SHALL set o_overflow on i_wr_en & o_full and o_underflow on i_rd_en & o_empty, both sticky until reset or flush.
REQ-029 SHALL, on i_flush=1 at an edge, zero both pointers, o_words, o_overflow and o_underflow, set o_empty=1 and o_almost_empty=1, and ignore concurrent i_wr_en and i_rd_en; memory contents need not be cleared.
REQ-030 SHALL preserve ordering: words are read in exactly the order written.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force wr_ptr=0, rd_ptr=0, o_words=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_underflow=0, and o_rd_data=0.
REQ-032 SHALL deassert reset synchronously to clk (external synchronizer), and accept the first write on the first edge after rst_n rises.
REQ-033 SHALL, when reset asserts mid-operation, lose all stored words with no partial outputs.

Verification (DW=64, N_log=4, AF_LVL=14, AE_LVL=2)
REQ-034 SHALL cover: write 16 words 0x0..0xF with reads idle -> o_full=1 after 16th edge, o_words=16, o_almost_full=1 from 14th; 17th write -> o_overflow=1, o_words stays 16.
REQ-035 SHALL cover: FWFT=0, read 16 words -> o_rd_data=0x0..0xF each one cycle after its read edge; o_empty=1 after 16th; extra read -> o_underflow=1.
REQ-036 SHALL cover: FWFT=1, single write 0xA5 into empty -> next cycle o_empty=0, o_rd_data=0xA5; pop -> o_empty=1.
REQ-037 SHALL cover: simultaneous write+read at o_words=0 -> write only, o_words=1; at o_words=16 -> read only, o_words=15; at o_words=8 -> o_words stays 8.
REQ-038 SHALL cover: 40 streaming writes/reads across wrap -> data in order, no loss; i_flush at o_words=5 with concurrent wr_en -> o_words=0, o_empty=1, errors cleared.
REQ-039 SHALL cover: rst_n pulsed low mid-stream at o_words=7 -> all outputs at reset values immediately, without a clock edge.
